cpu_run_control: RTL
====================

// Module: cpu_run_control
//
// PURPOSE
//   Run/halt/single-step gate between the 1 MHz clock-enable divider and the
//   6502 core. Qualifies each incoming tick into the CPU clock enable cpu_ce.
//   Applies debug halt, N-cycle stepping and peripheral wait-state stretching.
//   Keeps a free-running executed-cycle counter. The whole design stays in a
//   single clk domain; no derived clocks.
//
// PARAMETERS
//   CYCLE_W       32  width of cycle_count
//   STEP_W        16  width of step_count / steps_left
//   RESET_HALTED  0   1: leave reset in HALT; 0: leave reset in RUN
//
// PORTS
//   clk          in   1        system clock (25 MHz)
//   rst          in   1        reset, synchronous, active-high
//   tick_in      in   1        1-cycle enable pulse from divider (1 per 25 clk)
//   run_req      in   1        pulse: enter RUN
//   halt_req     in   1        pulse: enter HALT
//   step_req     in   1        pulse: from HALT, execute step_count CPU cycles
//   step_count   in   STEP_W   cycles per step request (0 treated as 1)
//   wait_req     in   1        level: peripheral stretch, suppresses cpu_ce
//   clr_count    in   1        pulse: clear cycle_count
//   cpu_ce       out  1        CPU clock enable (combinational, see below)
//   halted       out  1        registered, 1 when state==HALT
//   stepping     out  1        registered, 1 when state==STEP
//   steps_left   out  STEP_W   remaining cycles of current step
//   cycle_count  out  CYCLE_W  number of cpu_ce pulses issued, wraps
//
// BEHAVIOUR
// - FSM states: RUN, HALT, STEP.
// - Reset: state = HALT if RESET_HALTED else RUN; steps_left = 0;
//   cycle_count = 0; halted/stepping reflect the reset state.
// - cpu_ce = tick_in & (state==RUN | state==STEP) & ~wait_req.
//   - Zero latency relative to tick_in, using the registered state.
//   - cpu_ce is 0 while rst=1.
// - Wait states: a tick seen while wait_req=1 is dropped, not queued. The CPU
//   cycle is stretched to the next tick that has wait_req=0.
// - Request priority when pulses coincide: halt_req > step_req > run_req.
// - Transitions, all taking effect on the next clk edge:
//   - RUN: halt_req -> HALT. step_req and run_req are ignored.
//   - HALT: step_req -> STEP and load steps_left = (step_count==0 ? 1 : step_count).
//     run_req -> RUN.
//   - STEP: halt_req -> HALT and clear steps_left to 0 (abort).
//     run_req -> RUN and clear steps_left. step_req is ignored.
//   - STEP, on each cpu_ce: steps_left -= 1. When the decrement reaches 0 the
//     state becomes HALT on that same edge, so exactly N cpu_ce pulses are issued.
//   - A halt_req coinciding with a cpu_ce still lets that cpu_ce through. The
//     state becomes HALT on the same edge.
// - cycle_count: +1 on every cpu_ce, modulo 2^CYCLE_W.
//   - clr_count sets it to 0.
//   - If clr_count coincides with cpu_ce, the result is 1.
// - Reset mid-step or mid-run: everything returns to reset values immediately;
//   the in-progress step count is lost.
// - wait_req has no effect on state and does not consume steps.
//
// TESTING
// - rst, RESET_HALTED=0, free-running tick every 25 clk -> cpu_ce equals tick_in;
//   cycle_count=100 after 100 ticks.
// - halt_req in RUN -> halted=1 next clk; no cpu_ce across 10 ticks;
//   cycle_count frozen.
// - In HALT, step_req with step_count=3 -> exactly 3 cpu_ce pulses, then
//   halted=1. Repeat with step_count=0 -> exactly 1 pulse.
// - step_count=5 with wait_req held high across ticks 2-3 -> those ticks are
//   dropped; 5 cpu_ce still issued; steps_left never decrements on a dropped tick.
// - halt_req, step_req and run_req in the same cycle from RUN -> HALT;
//   halt_req during STEP with steps_left=4 -> HALT, steps_left=0.
// - cycle_count at 2^CYCLE_W-1 (CYCLE_W=8 build), one cpu_ce -> wraps to 0;
//   clr_count with cpu_ce -> 1; rst mid-STEP -> reset values on next clk.

Source files
------------

// File: rtl/cpu_run_control.sv
// cpu_run_control
//   Run/halt/single-step gate between the 1 MHz clock-enable divider and the
//   6502 core. Each incoming tick is qualified into the CPU clock enable
//   (cpu_ce) according to the run state and the peripheral wait request.
//   A free-running counter records every CPU cycle actually issued.
//
// Ports
//   clk         system clock
//   rst         synchronous, active-high reset
//   tick_in     1-cycle enable pulse from the clock divider
//   run_req     pulse: enter RUN
//   halt_req    pulse: enter HALT (highest priority)
//   step_req    pulse: from HALT, execute step_count CPU cycles
//   step_count  CPU cycles per step request (0 behaves as 1)
//   wait_req    level: peripheral stretch, drops ticks while high
//   clr_count   pulse: clear cycle_count
//   cpu_ce      CPU clock enable (combinational from tick_in)
//   halted      registered, state is HALT
//   stepping    registered, state is STEP
//   steps_left  CPU cycles remaining in the current step
//   cycle_count number of cpu_ce pulses issued, wraps
module cpu_run_control #(
  parameter int CYCLE_W      = 32,
  parameter int STEP_W       = 16,
  parameter bit RESET_HALTED = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_in,
  input  logic               run_req,
  input  logic               halt_req,
  input  logic               step_req,
  input  logic [STEP_W-1:0]  step_count,
  input  logic               wait_req,
  input  logic               clr_count,
  output logic               cpu_ce,
  output logic               halted,
  output logic               stepping,
  output logic [STEP_W-1:0]  steps_left,
  output logic [CYCLE_W-1:0] cycle_count
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_HALT = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;

  localparam logic [1:0] ST_RESET = RESET_HALTED ? ST_HALT : ST_RUN;

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [STEP_W-1:0]  r_steps_left;
  logic [STEP_W-1:0]  w_steps_next;
  logic [CYCLE_W-1:0] r_cycle_count;
  logic               r_halted;
  logic               r_stepping;
  logic               w_ce;

  // Ticks seen while wait_req is high are simply lost; the CPU cycle is
  // stretched until the next tick with wait_req low. rst gates the enable
  // so the core never advances while reset is held.
  assign w_ce = tick_in & ~wait_req & ~rst &
                ((r_state == ST_RUN) | (r_state == ST_STEP));

  always_comb begin
    w_state_next = r_state;
    w_steps_next = r_steps_left;
    case (r_state)
      ST_RUN: begin
        if (halt_req) begin
          w_state_next = ST_HALT;
        end
      end
      ST_HALT: begin
        if (halt_req) begin
          w_state_next = ST_HALT;
        end else if (step_req) begin
          w_state_next = ST_STEP;
          w_steps_next = (step_count == '0) ? STEP_W'(1) : step_count;
        end else if (run_req) begin
          w_state_next = ST_RUN;
        end
      end
      ST_STEP: begin
        // A cpu_ce coinciding with an abort still goes out (w_ce is
        // independent of the requests); only the bookkeeping is dropped.
        if (halt_req) begin
          w_state_next = ST_HALT;
          w_steps_next = '0;
        end else if (run_req) begin
          w_state_next = ST_RUN;
          w_steps_next = '0;
        end else if (w_ce) begin
          w_steps_next = r_steps_left - 1'b1;
          // Leave on the edge of the last issued cycle so exactly N pulses go out.
          if (r_steps_left == STEP_W'(1)) begin
            w_state_next = ST_HALT;
          end
        end
      end
      default: begin
        w_state_next = ST_RESET;
        w_steps_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_RESET;
      r_steps_left <= '0;
      r_halted     <= (ST_RESET == ST_HALT);
      r_stepping   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_steps_left <= w_steps_next;
      r_halted     <= (w_state_next == ST_HALT);
      r_stepping   <= (w_state_next == ST_STEP);
    end
  end

  // Clear and count in the same cycle leaves the count at 1: the cleared
  // value plus the cycle just issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_count <= '0;
    end else if (clr_count) begin
      r_cycle_count <= w_ce ? CYCLE_W'(1) : '0;
    end else if (w_ce) begin
      r_cycle_count <= r_cycle_count + 1'b1;
    end
  end

  assign cpu_ce      = w_ce;
  assign halted      = r_halted;
  assign stepping    = r_stepping;
  assign steps_left  = r_steps_left;
  assign cycle_count = r_cycle_count;

endmodule
